// File: rtl/matrix_pkg.sv
// Shared types and width helpers for the sequenced matrix multiplier.
// Widths are derived here so the top and the rounding stage agree on them.
package matrix_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MAC,
    S_ROUND,
    S_OUT,
    S_DONE
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int p = 1; p < v; p = p * 2) r++;
    return r;
  endfunction

  function automatic int addr_width(input int n);
    return clog2(n * n);
  endfunction

  // Sum of n full-precision products can never overflow this width.
  function automatic int acc_width(input int dw, input int n);
    return 2 * dw + clog2(n);
  endfunction

  function automatic logic signed [127:0] smax(input int dw);
    return (128'sd1 <<< (dw - 1)) - 128'sd1;
  endfunction

  function automatic logic signed [127:0] smin(input int dw);
    return -(128'sd1 <<< (dw - 1));
  endfunction

endpackage

// File: rtl/matrix_round_sat.sv
// Combinational round-half-up, shift by FRAC, then saturate or wrap to DW.
// ovf_o flags any result outside the signed DW range, whichever mode is built.
module matrix_round_sat
  import matrix_pkg::*;
#(
  parameter int DW   = 32,
  parameter int ACCW = 66,
  parameter int FRAC = 0,
  parameter int SAT  = 1
) (
  input  logic signed [ACCW-1:0] acc_i,
  output logic        [DW-1:0]   res_o,
  output logic                   ovf_o
);

  localparam logic signed [ACCW-1:0] RND  = ACCW'((128'd1 << FRAC) >> 1);
  localparam logic signed [ACCW-1:0] MAXV = ACCW'(smax(DW));
  localparam logic signed [ACCW-1:0] MINV = ACCW'(smin(DW));

  logic signed [ACCW-1:0] sum;
  logic signed [ACCW-1:0] t;
  logic                   hi;
  logic                   lo;

  assign sum = acc_i + RND;
  assign t   = sum >>> FRAC;

  always_comb begin
    hi    = t > MAXV;
    lo    = t < MINV;
    ovf_o = hi | lo;
    res_o = t[DW-1:0];
    if (SAT != 0 && hi) res_o = MAXV[DW-1:0];
    else if (SAT != 0 && lo) res_o = MINV[DW-1:0];
  end

endmodule

// File: rtl/matrix_mul_seq.sv
// Sequenced NxN signed matrix multiply R = A x B, one MAC per cycle.
// Operands live in local register storage; results stream out row-major.
module matrix_mul_seq
  import matrix_pkg::*;
#(
  parameter int N    = 4,
  parameter int DW   = 32,
  parameter int FRAC = 0,
  parameter int SAT  = 1,
  localparam int AW   = addr_width(N),
  localparam int ACCW = acc_width(DW, N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_we,
  input  logic [AW-1:0] a_waddr,
  input  logic [DW-1:0] a_wdata,
  input  logic          b_we,
  input  logic [AW-1:0] b_waddr,
  input  logic [DW-1:0] b_wdata,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          ovf,
  output logic          r_valid,
  input  logic          r_ready,
  output logic [DW-1:0] r_data,
  output logic [AW-1:0] r_addr,
  output logic          r_last
);

  localparam int            IW       = clog2(N);
  localparam int            NE       = N * N;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
  localparam logic [AW-1:0] N_AW     = AW'(N);

  state_e                 state_q, state_d;
  logic [DW-1:0]          a_mem_q [NE];
  logic [DW-1:0]          b_mem_q [NE];
  logic [IW-1:0]          i_q, i_d, j_q, j_d, k_q, k_d;
  logic signed [ACCW-1:0] acc_q, acc_d;
  logic [DW-1:0]          r_data_q, r_data_d;
  logic [AW-1:0]          r_addr_q, r_addr_d;
  logic                   r_last_q, r_last_d;
  logic                   ovf_q, ovf_d;

  logic [AW-1:0]          a_raddr, b_raddr;
  logic [DW-1:0]          a_elem, b_elem;
  logic signed [2*DW-1:0] a_ext, b_ext, prod;
  logic [DW-1:0]          rs_data;
  logic                   rs_ovf;

  assign a_raddr = AW'(i_q) * N_AW + AW'(k_q);
  assign b_raddr = AW'(k_q) * N_AW + AW'(j_q);
  assign a_elem  = a_mem_q[a_raddr];
  assign b_elem  = b_mem_q[b_raddr];
  assign a_ext   = $signed({{DW{a_elem[DW-1]}}, a_elem});
  assign b_ext   = $signed({{DW{b_elem[DW-1]}}, b_elem});
  assign prod    = a_ext * b_ext;

  matrix_round_sat #(
    .DW  (DW),
    .ACCW(ACCW),
    .FRAC(FRAC),
    .SAT (SAT)
  ) u_round (
    .acc_i(acc_q),
    .res_o(rs_data),
    .ovf_o(rs_ovf)
  );

  // Operand storage only accepts writes while idle so a run sees stable inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int e = 0; e < NE; e++) begin
        a_mem_q[e] <= '0;
        b_mem_q[e] <= '0;
      end
    end else if (state_q == S_IDLE) begin
      if (a_we) a_mem_q[a_waddr] <= a_wdata;
      if (b_we) b_mem_q[b_waddr] <= b_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      acc_q    <= '0;
      r_data_q <= '0;
      r_addr_q <= '0;
      r_last_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      j_q      <= j_d;
      k_q      <= k_d;
      acc_q    <= acc_d;
      r_data_q <= r_data_d;
      r_addr_q <= r_addr_d;
      r_last_q <= r_last_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    j_d      = j_q;
    k_d      = k_q;
    acc_d    = acc_q;
    r_data_d = r_data_q;
    r_addr_d = r_addr_q;
    r_last_d = r_last_q;
    ovf_d    = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_MAC;
          ovf_d   = 1'b0;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
        end
      end
      S_MAC: begin
        // k==0 restarts the sum so no separate clear cycle is needed.
        acc_d = ((k_q == '0) ? '0 : acc_q) + ACCW'(prod);
        if (k_q == LAST_IDX) begin
          k_d     = '0;
          state_d = S_ROUND;
        end else begin
          k_d = k_q + IW'(1);
        end
      end
      S_ROUND: begin
        r_data_d = rs_data;
        r_addr_d = AW'(i_q) * N_AW + AW'(j_q);
        r_last_d = (i_q == LAST_IDX) && (j_q == LAST_IDX);
        if (rs_ovf) ovf_d = 1'b1;
        state_d = S_OUT;
      end
      S_OUT: begin
        if (r_ready) begin
          state_d = S_MAC;
          if (j_q == LAST_IDX) begin
            j_d = '0;
            if (i_q == LAST_IDX) begin
              i_d     = '0;
              state_d = S_DONE;
            end else begin
              i_d = i_q + IW'(1);
            end
          end else begin
            j_d = j_q + IW'(1);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy    = (state_q == S_MAC) || (state_q == S_ROUND) || (state_q == S_OUT);
  assign done    = (state_q == S_DONE);
  assign r_valid = (state_q == S_OUT);
  assign r_last  = r_last_q && (state_q == S_OUT);
  assign r_data  = r_data_q;
  assign r_addr  = r_addr_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_matrix_mul_seq.sv
// Directed bench for matrix_mul_seq: three builds (default, FRAC=16, SAT=0)
// share one input stream and run in lockstep; each task checks one feature.
module tb_matrix_mul_seq;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int NE = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          a_we = 1'b0, b_we = 1'b0, start = 1'b0, r_ready = 1'b1;
  logic [AW-1:0] a_waddr = '0, b_waddr = '0;
  logic [DW-1:0] a_wdata = '0, b_wdata = '0;

  logic          busy0, done0, ovf0, rv0, last0;
  logic [DW-1:0] rd0;
  logic [AW-1:0] ra0;
  logic          busyf, donef, ovff, rvf, lastf;
  logic [DW-1:0] rdf;
  logic [AW-1:0] raf;
  logic          busyw, donew, ovfw, rvw, lastw;
  logic [DW-1:0] rdw;
  logic [AW-1:0] raw;

  matrix_mul_seq #(.N(N), .DW(DW), .FRAC(0), .SAT(1)) dut0 (
    .clk(clk), .rst(rst), .a_we(a_we), .a_waddr(a_waddr), .a_wdata(a_wdata),
    .b_we(b_we), .b_waddr(b_waddr), .b_wdata(b_wdata), .start(start),
    .busy(busy0), .done(done0), .ovf(ovf0), .r_valid(rv0), .r_ready(r_ready),
    .r_data(rd0), .r_addr(ra0), .r_last(last0));

  matrix_mul_seq #(.N(N), .DW(DW), .FRAC(16), .SAT(1)) dut_frac (
    .clk(clk), .rst(rst), .a_we(a_we), .a_waddr(a_waddr), .a_wdata(a_wdata),
    .b_we(b_we), .b_waddr(b_waddr), .b_wdata(b_wdata), .start(start),
    .busy(busyf), .done(donef), .ovf(ovff), .r_valid(rvf), .r_ready(r_ready),
    .r_data(rdf), .r_addr(raf), .r_last(lastf));

  matrix_mul_seq #(.N(N), .DW(DW), .FRAC(0), .SAT(0)) dut_wrap (
    .clk(clk), .rst(rst), .a_we(a_we), .a_waddr(a_waddr), .a_wdata(a_wdata),
    .b_we(b_we), .b_waddr(b_waddr), .b_wdata(b_wdata), .start(start),
    .busy(busyw), .done(donew), .ovf(ovfw), .r_valid(rvw), .r_ready(r_ready),
    .r_data(rdw), .r_addr(raw), .r_last(lastw));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int passed = 0, total = 0;
  logic [DW-1:0] ma [NE];
  logic [DW-1:0] mb [NE];
  logic [DW-1:0] res0 [NE];
  logic [DW-1:0] resf [NE];
  logic [DW-1:0] resw [NE];
  logic [AW-1:0] res_addr [NE];
  logic          res_last [NE];
  int  t0, t_first, t_done, n_res, n_stall;
  bit  ovf_cleared, stable_ok, lock_ok;

  task automatic load_mats(input bit skip_b15);
    for (int e = 0; e < NE; e++) begin
      @(posedge clk); #1;
      a_we = 1'b1; a_waddr = AW'(e); a_wdata = ma[e];
      b_we = !(skip_b15 && e == NE - 1); b_waddr = AW'(e); b_wdata = mb[e];
    end
    @(posedge clk); #1;
    a_we = 1'b0; b_we = 1'b0;
  endtask

  task automatic run_mult(input bit wr_b15, input logic [DW-1:0] b15,
                          input int stall_addr, input int stall_len, input bit disturb);
    logic [DW-1:0] held_d;
    logic [AW-1:0] held_a;
    held_d = '0; held_a = '0;
    n_res = 0; t_first = -1; t_done = -1; n_stall = 0;
    stable_ok = 1'b1; lock_ok = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; r_ready = 1'b1; t0 = cyc;
    if (wr_b15) begin b_we = 1'b1; b_waddr = AW'(15); b_wdata = b15; end
    @(posedge clk); #1;
    start = 1'b0; b_we = 1'b0;
    ovf_cleared = (ovf0 == 1'b0);
    for (int c = 0; c < 400; c++) begin
      if (disturb && (cyc - t0) >= 2 && (cyc - t0) <= 20) begin
        start = 1'b1; a_we = 1'b1; b_we = 1'b1;
        a_waddr = AW'(cyc); b_waddr = AW'(cyc + 3);
        a_wdata = 32'h5555_5555; b_wdata = 32'hAAAA_AAAA;
      end else begin
        start = 1'b0; a_we = 1'b0; b_we = 1'b0;
      end
      @(negedge clk);
      if (rvf !== rv0 || rvw !== rv0 || raf !== ra0 || raw !== ra0 || busyf !== busy0 ||
          busyw !== busy0 || donef !== done0 || donew !== done0 || lastf !== last0 ||
          lastw !== last0)
        lock_ok = 1'b0;
      if (rv0) begin
        if (t_first < 0) t_first = cyc;
        if (int'(ra0) == stall_addr && n_stall < stall_len) begin
          if (n_stall == 0) begin held_d = rd0; held_a = ra0; end
          else if (rd0 !== held_d || ra0 !== held_a) stable_ok = 1'b0;
          n_stall++;
          r_ready = 1'b0;
        end else begin
          if (n_stall > 0 && int'(ra0) == stall_addr && rd0 !== held_d) stable_ok = 1'b0;
          r_ready = 1'b1;
          if (n_res < NE) begin
            res0[n_res] = rd0; resf[n_res] = rdf; resw[n_res] = rdw;
            res_addr[n_res] = ra0; res_last[n_res] = last0;
          end
          n_res++;
        end
      end
      if (done0) begin
        t_done = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    start = 1'b0; a_we = 1'b0; b_we = 1'b0; r_ready = 1'b1;
    $display("run t0=%0d first=+%0d done=+%0d results=%0d ovf=%0b", t0, t_first - t0,
             t_done - t0, n_res, ovf0);
  endtask

  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    total++; if (busy0 !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy0); else passed++;
    total++; if (done0 !== 1'b0) $display("FAIL rst_done: got %b want 0", done0); else passed++;
    total++; if (ovf0 !== 1'b0) $display("FAIL rst_ovf: got %b want 0", ovf0); else passed++;
    total++; if (rv0 !== 1'b0) $display("FAIL rst_valid: got %b want 0", rv0); else passed++;
    total++; if (last0 !== 1'b0) $display("FAIL rst_last: got %b want 0", last0); else passed++;
    total++; if (rd0 !== 32'h0) $display("FAIL rst_data: got %h want 0", rd0); else passed++;
    total++; if (ra0 !== 4'h0) $display("FAIL rst_addr: got %h want 0", ra0); else passed++;
    rst = 1'b0;
  endtask

  task automatic test_identity();
    for (int e = 0; e < NE; e++) begin
      ma[e] = (e % 5 == 0) ? 32'd1 : 32'd0;
      mb[e] = 32'(e + 1);
    end
    load_mats(1'b1);
    run_mult(1'b1, 32'd16, -1, 0, 1'b0);
    total++; if (n_res !== NE) $display("FAIL id_count: got %0d want %0d", n_res, NE); else passed++;
    total++; if (t_first - t0 !== 6) $display("FAIL id_first: got %0d want 6", t_first - t0); else passed++;
    total++; if (t_done - t0 !== 97) $display("FAIL id_done: got %0d want 97", t_done - t0); else passed++;
    total++; if (ovf0 !== 1'b0) $display("FAIL id_ovf: got %b want 0", ovf0); else passed++;
    total++; if (!lock_ok) $display("FAIL id_lockstep: got 0 want 1"); else passed++;
    for (int e = 0; e < NE; e++) begin
      total++; if (res_addr[e] !== AW'(e)) $display("FAIL id_addr%0d: got %0d want %0d", e, res_addr[e], e); else passed++;
      total++; if (res0[e] !== 32'(e + 1)) $display("FAIL id_data%0d: got %h want %h", e, res0[e], e + 1); else passed++;
      total++; if (res_last[e] !== (e == NE - 1)) $display("FAIL id_last%0d: got %b want %b", e, res_last[e], e == NE - 1); else passed++;
    end
  endtask

  task automatic test_stall();
    run_mult(1'b0, 32'd0, 3, 5, 1'b0);
    total++; if (n_res !== NE) $display("FAIL st_count: got %0d want %0d", n_res, NE); else passed++;
    total++; if (n_stall !== 5) $display("FAIL st_stalls: got %0d want 5", n_stall); else passed++;
    total++; if (!stable_ok) $display("FAIL st_stable: got 0 want 1"); else passed++;
    total++; if (t_done - t0 !== 102) $display("FAIL st_done: got %0d want 102", t_done - t0); else passed++;
    for (int e = 0; e < NE; e++) begin
      total++; if (res_addr[e] !== AW'(e) || res0[e] !== 32'(e + 1))
        $display("FAIL st_elem%0d: got addr %0d data %h want addr %0d data %h", e, res_addr[e], res0[e], e, e + 1);
      else passed++;
    end
  endtask

  task automatic test_saturate();
    for (int e = 0; e < NE; e++) begin ma[e] = 32'h7FFF_FFFF; mb[e] = 32'd2; end
    load_mats(1'b0);
    run_mult(1'b0, 32'd0, -1, 0, 1'b0);
    total++; if (ovf0 !== 1'b1) $display("FAIL sat_ovf: got %b want 1", ovf0); else passed++;
    total++; if (ovfw !== 1'b1) $display("FAIL wrap_ovf: got %b want 1", ovfw); else passed++;
    for (int e = 0; e < NE; e++) begin
      total++; if (res0[e] !== 32'h7FFF_FFFF) $display("FAIL sat_data%0d: got %h want 7fffffff", e, res0[e]); else passed++;
      total++; if (resw[e] !== 32'hFFFF_FFF8) $display("FAIL wrap_data%0d: got %h want fffffff8", e, resw[e]); else passed++;
    end
    for (int e = 0; e < NE; e++) ma[e] = (e % 5 == 0) ? 32'd1 : 32'd0;
    load_mats(1'b0);
    total++; if (ovf0 !== 1'b1) $display("FAIL sat_ovf_held: got %b want 1", ovf0); else passed++;
    run_mult(1'b0, 32'd0, -1, 0, 1'b0);
    total++; if (!ovf_cleared) $display("FAIL sat_ovf_clear: got 1 want 0"); else passed++;
    total++; if (ovf0 !== 1'b0) $display("FAIL sat_ovf_after: got %b want 0", ovf0); else passed++;
    for (int e = 0; e < NE; e++) begin
      total++; if (res0[e] !== 32'd2) $display("FAIL sat_rerun%0d: got %h want 2", e, res0[e]); else passed++;
    end
  endtask

  task automatic test_frac();
    for (int e = 0; e < NE; e++) begin
      ma[e] = (e % 5 == 0) ? 32'h0001_8000 : 32'd0;
      mb[e] = 32'h0002_0000;
    end
    load_mats(1'b0);
    run_mult(1'b0, 32'd0, -1, 0, 1'b0);
    total++; if (ovff !== 1'b0) $display("FAIL frac_ovf: got %b want 0", ovff); else passed++;
    for (int e = 0; e < NE; e++) begin
      total++; if (resf[e] !== 32'h0003_0000) $display("FAIL frac_data%0d: got %h want 00030000", e, resf[e]); else passed++;
    end
    for (int e = 0; e < NE; e++) begin ma[e] = 32'd0; mb[e] = 32'd0; end
    ma[0] = 32'd1; mb[0] = 32'h0000_8000;
    load_mats(1'b0);
    run_mult(1'b0, 32'd0, -1, 0, 1'b0);
    total++; if (resf[0] !== 32'd1) $display("FAIL frac_half_up: got %h want 1", resf[0]); else passed++;
    total++; if (resf[1] !== 32'd0) $display("FAIL frac_zero: got %h want 0", resf[1]); else passed++;
    ma[0] = 32'hFFFF_FFFF;
    load_mats(1'b0);
    run_mult(1'b0, 32'd0, -1, 0, 1'b0);
    total++; if (resf[0] !== 32'd0) $display("FAIL frac_neg_half: got %h want 0", resf[0]); else passed++;
  endtask

  task automatic test_reset_mid();
    bit found;
    found = 1'b0;
    for (int e = 0; e < NE; e++) begin ma[e] = 32'h7FFF_FFFF; mb[e] = 32'd2; end
    load_mats(1'b0);
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (rv0 && ra0 == 4'd5) begin found = 1'b1; break; end
    end
    total++; if (!found) $display("FAIL rm_reach_addr5: got timeout want addr 5"); else passed++;
    total++; if (ovf0 !== 1'b1) $display("FAIL rm_ovf_before: got %b want 1", ovf0); else passed++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (busy0 !== 1'b0) $display("FAIL rm_busy: got %b want 0", busy0); else passed++;
    total++; if (rv0 !== 1'b0) $display("FAIL rm_valid: got %b want 0", rv0); else passed++;
    total++; if (ovf0 !== 1'b0) $display("FAIL rm_ovf: got %b want 0", ovf0); else passed++;
    run_mult(1'b0, 32'd0, -1, 0, 1'b0);
    total++; if (n_res !== NE) $display("FAIL rm_count: got %0d want %0d", n_res, NE); else passed++;
    for (int e = 0; e < NE; e++) begin
      total++; if (res0[e] !== 32'd0) $display("FAIL rm_zero%0d: got %h want 0", e, res0[e]); else passed++;
    end
  endtask

  task automatic test_busy_ignored();
    bit quiet;
    for (int e = 0; e < NE; e++) begin
      ma[e] = (e % 5 == 0) ? 32'd1 : 32'd0;
      mb[e] = 32'(e + 1);
    end
    load_mats(1'b0);
    run_mult(1'b0, 32'd0, -1, 0, 1'b1);
    total++; if (t_done - t0 !== 97) $display("FAIL bz_done: got %0d want 97", t_done - t0); else passed++;
    total++; if (n_res !== NE) $display("FAIL bz_count: got %0d want %0d", n_res, NE); else passed++;
    for (int e = 0; e < NE; e++) begin
      total++; if (res0[e] !== 32'(e + 1)) $display("FAIL bz_data%0d: got %h want %h", e, res0[e], e + 1); else passed++;
    end
    quiet = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (busy0 !== 1'b0 || rv0 !== 1'b0) quiet = 1'b0;
    end
    total++; if (!quiet) $display("FAIL bz_no_second_run: got busy/valid want idle"); else passed++;
    run_mult(1'b0, 32'd0, -1, 0, 1'b0);
    for (int e = 0; e < NE; e++) begin
      total++; if (res0[e] !== 32'(e + 1)) $display("FAIL bz_store%0d: got %h want %h", e, res0[e], e + 1); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_stall();
    test_saturate();
    test_frac();
    test_reset_mid();
    test_busy_ignored();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
